gabor_window_gen: RTL and testbench
===================================

GABOR_WINDOW_GEN -- requirements
Module: gabor_window_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 516, meaning padded image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 516, meaning padded image height in rows.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port pix_in, input, 8 bits: raster-order padded-image pixel.
REQ-006 SHALL have port pix_valid, input, 1 bit: pix_in valid.
REQ-007 SHALL have port pix_ready, output, 1 bit: block accepts pix_in this cycle.
REQ-008 SHALL have ports pixel1..pixel25, output, 10 bits each: 5x5 window for conv, zero-extended {2'b00,pix}.
REQ-009 SHALL have port win_valid, output, 1 bit: window outputs valid.
REQ-010 SHALL have port win_ready, input, 1 bit: consumer takes the window.
REQ-011 SHALL have port frame_done, output, 1 bit: set with the last window of a frame.

Function
REQ-012 SHALL accept a pixel only when pix_valid && pix_ready; pix_ready = rst && (!win_valid || win_ready), combinational.
REQ-013 SHALL keep col (0..IMG_W-1) and row (0..IMG_H-1) counters of the next accepted pixel; col wraps at IMG_W-1 and increments row; row wraps at IMG_H-1 to 0, starting the next frame.
REQ-014 SHALL keep 4 line buffers of IMG_W x 8 bits plus a 5x5 shift window; each accepted pixel shifts in column-wise.
REQ-015 SHALL place the oldest row/column at pixel1 and the current pixel at pixel25, row-major: pixel(5r+c+1) = image[row-4+r][col-4+c].
REQ-016 SHALL register outputs; win_valid SHALL assert the cycle after accepting a pixel with row>=4 and col>=4; latency is 1 cycle.
REQ-017 SHALL hold win_valid and all pixelN stable while win_valid && !win_ready.
REQ-018 SHALL clear win_valid when win_ready is high and no new qualifying pixel is accepted in the same cycle; a simultaneous take and accept loads the new window with win_valid staying 1.
REQ-019 SHALL produce (IMG_W-4)*(IMG_H-4) windows per frame, 262144 at defaults.
REQ-020 SHALL assert frame_done with the window from pixel (IMG_H-1, IMG_W-1) and hold it with win_valid.
REQ-021 SHALL NOT clear line buffers at frame wrap; rows 0..3 of a new frame produce no windows.

Reset
REQ-022 SHALL, when rst=0 at a clock edge, set col=0, row=0, win_valid=0, frame_done=0 and pixel1..pixel25=0.
REQ-023 SHALL drive pix_ready=0 while rst=0; line buffer and window contents need no reset.
REQ-024 SHALL restart from pixel (0,0) after reset mid-frame and discard any partial frame.

Configuration
REQ-025 SHALL, with GABOR_WIN_COORD_EN defined, add output ports win_x and win_y, 9 bits each: window top-left position in the unpadded image (col-4, row-4), registered with the window.
REQ-026 SHALL, without GABOR_WIN_COORD_EN, omit win_x and win_y with other behaviour unchanged.

Verification
REQ-027 SHALL verify ramp frame pix=(row*516+col) mod 256, pix_valid=1, win_ready=1 -> first win_valid one cycle after the 2069th accepted pixel; pixel1=0, pixel13=10, pixel25=20.
REQ-028 SHALL verify a full frame -> exactly 262144 win_valid cycles; frame_done only on the last, with pixel25=(266255 mod 256)=15.
REQ-029 SHALL verify win_ready=0 for 10 cycles while win_valid=1 -> pix_ready=0, outputs unchanged for 10 cycles, no pixel lost.
REQ-030 SHALL verify random pix_valid gaps (50% duty) -> window sequence identical to the no-gap run.
REQ-031 SHALL verify rst=0 for 1 cycle at row 100 -> win_valid=0 next cycle; the first window of the restarted frame appears after 2069 accepted pixels.
REQ-032 SHALL verify, with GABOR_WIN_COORD_EN, that win_x/win_y = 0/0 on the first window and 511/511 on the frame_done window.

Source files
------------

// File: rtl/gabor_window_gen.sv
// 5x5 sliding-window generator for a raster-order padded image, built from four line buffers.
// Optional GABOR_WIN_COORD_EN adds the win_x/win_y window-origin outputs.
module gabor_window_gen #(
    parameter int IMG_W = 516,
    parameter int IMG_H = 516
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic [9:0] pixel1,
    output logic [9:0] pixel2,
    output logic [9:0] pixel3,
    output logic [9:0] pixel4,
    output logic [9:0] pixel5,
    output logic [9:0] pixel6,
    output logic [9:0] pixel7,
    output logic [9:0] pixel8,
    output logic [9:0] pixel9,
    output logic [9:0] pixel10,
    output logic [9:0] pixel11,
    output logic [9:0] pixel12,
    output logic [9:0] pixel13,
    output logic [9:0] pixel14,
    output logic [9:0] pixel15,
    output logic [9:0] pixel16,
    output logic [9:0] pixel17,
    output logic [9:0] pixel18,
    output logic [9:0] pixel19,
    output logic [9:0] pixel20,
    output logic [9:0] pixel21,
    output logic [9:0] pixel22,
    output logic [9:0] pixel23,
    output logic [9:0] pixel24,
    output logic [9:0] pixel25,
    output logic       win_valid,
    input  logic       win_ready,
    output logic       frame_done
`ifdef GABOR_WIN_COORD_EN
    ,
    output logic [8:0] win_x,
    output logic [8:0] win_y
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          win_valid_q, win_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          accept;
    logic          qualify;
    logic [CW-1:0] rd_addr;
    logic [7:0]    col_vec [5];
    logic [7:0]    win_q [5][5];

    assign pix_ready = rst && (!win_valid_q || win_ready);
    assign accept    = pix_valid && pix_ready;
    assign qualify   = (row_q >= RW'(4)) && (col_q >= CW'(4));

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_valid_d  = win_valid_q;
        frame_done_d = frame_done_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            win_valid_d  = qualify;
            frame_done_d = qualify && (col_q == COL_LAST) && (row_q == ROW_LAST);
        end else if (win_ready) begin
            win_valid_d  = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    // Read one column ahead so the line-buffer data is ready for back-to-back accepts.
    assign rd_addr    = rst ? col_d : '0;
    assign col_vec[4] = pix_in;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lb
            logic [7:0] mem [IMG_W];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (accept) begin
                    mem[col_q] <= col_vec[4-gi];
                end
                rd_q <= mem[rd_addr];
            end

            assign col_vec[3-gi] = rd_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // The window shifts on every accept so the leftmost columns are primed before col 4.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][4] <= col_vec[r];
            end
        end
    end

`ifdef GABOR_WIN_COORD_EN
    logic [8:0] win_x_q, win_x_d;
    logic [8:0] win_y_q, win_y_d;

    always_comb begin
        win_x_d = win_x_q;
        win_y_d = win_y_q;
        if (accept && qualify) begin
            win_x_d = 9'(col_q - CW'(4));
            win_y_d = 9'(row_q - RW'(4));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            win_x_q <= '0;
            win_y_q <= '0;
        end else begin
            win_x_q <= win_x_d;
            win_y_q <= win_y_d;
        end
    end

    assign win_x = win_x_q;
    assign win_y = win_y_q;
`endif

    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

    assign pixel1  = {2'b00, win_q[0][0]};
    assign pixel2  = {2'b00, win_q[0][1]};
    assign pixel3  = {2'b00, win_q[0][2]};
    assign pixel4  = {2'b00, win_q[0][3]};
    assign pixel5  = {2'b00, win_q[0][4]};
    assign pixel6  = {2'b00, win_q[1][0]};
    assign pixel7  = {2'b00, win_q[1][1]};
    assign pixel8  = {2'b00, win_q[1][2]};
    assign pixel9  = {2'b00, win_q[1][3]};
    assign pixel10 = {2'b00, win_q[1][4]};
    assign pixel11 = {2'b00, win_q[2][0]};
    assign pixel12 = {2'b00, win_q[2][1]};
    assign pixel13 = {2'b00, win_q[2][2]};
    assign pixel14 = {2'b00, win_q[2][3]};
    assign pixel15 = {2'b00, win_q[2][4]};
    assign pixel16 = {2'b00, win_q[3][0]};
    assign pixel17 = {2'b00, win_q[3][1]};
    assign pixel18 = {2'b00, win_q[3][2]};
    assign pixel19 = {2'b00, win_q[3][3]};
    assign pixel20 = {2'b00, win_q[3][4]};
    assign pixel21 = {2'b00, win_q[4][0]};
    assign pixel22 = {2'b00, win_q[4][1]};
    assign pixel23 = {2'b00, win_q[4][2]};
    assign pixel24 = {2'b00, win_q[4][3]};
    assign pixel25 = {2'b00, win_q[4][4]};

endmodule

// File: tb/tb_gabor_window_gen.sv
// Directed bench for gabor_window_gen on a reduced 18x20 ramp image (pix = (row*18+col) mod 256).
// Build with +define+GABOR_WIN_COORD_EN to also check win_x/win_y.
module tb_gabor_window_gen;
    localparam int W = 18;
    localparam int H = 20;
    localparam int NWIN = (W - 4) * (H - 4);

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       pix_ready;
    logic       win_valid;
    logic       win_ready;
    logic       frame_done;
    logic [9:0] pix_o [25];
`ifdef GABOR_WIN_COORD_EN
    logic [8:0] win_x, win_y;
`endif

    always #5 clk = ~clk;

    gabor_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pixel1(pix_o[0]), .pixel2(pix_o[1]), .pixel3(pix_o[2]), .pixel4(pix_o[3]), .pixel5(pix_o[4]),
        .pixel6(pix_o[5]), .pixel7(pix_o[6]), .pixel8(pix_o[7]), .pixel9(pix_o[8]), .pixel10(pix_o[9]),
        .pixel11(pix_o[10]), .pixel12(pix_o[11]), .pixel13(pix_o[12]), .pixel14(pix_o[13]),
        .pixel15(pix_o[14]), .pixel16(pix_o[15]), .pixel17(pix_o[16]), .pixel18(pix_o[17]),
        .pixel19(pix_o[18]), .pixel20(pix_o[19]), .pixel21(pix_o[20]), .pixel22(pix_o[21]),
        .pixel23(pix_o[22]), .pixel24(pix_o[23]), .pixel25(pix_o[24]),
        .win_valid(win_valid), .win_ready(win_ready), .frame_done(frame_done)
`ifdef GABOR_WIN_COORD_EN
        , .win_x(win_x), .win_y(win_y)
`endif
    );

    typedef struct {
        int         idx;
        logic       vld;
        logic [7:0] p1;
        logic [7:0] p13;
        logic [7:0] p25;
        logic       fd;
    } vec_t;

    vec_t       tbl [12];
    int         checks = 0;
    int         errors = 0;
    int         mrow, mcol, n_win, n_fd, n_acc;
    logic       exp_valid, exp_fd;
    logic [7:0] exp_win [25];
    int         exp_x, exp_y;

    function automatic logic [7:0] img(input int r, input int c);
        return 8'((r * W + c) % 256);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_win(input string name);
        int bad;
        bad = -1;
        for (int k = 0; k < 25; k++)
            if (pix_o[k] !== {2'b00, exp_win[k]} && bad < 0) bad = k;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s pixel%0d actual %0d expected %0d (time %0t)", name, bad + 1,
                     pix_o[bad], exp_win[bad], $time);
        end
    endtask

    // One clock cycle: drive, check pix_ready, advance the reference model, check outputs.
    task automatic cyc(input logic v, input logic wr);
        logic exp_pr, acc;
        pix_valid = v;
        win_ready = wr;
        pix_in    = img(mrow, mcol);
        #1;
        exp_pr = rst && (!exp_valid || wr);
        chk("pix_ready", {31'd0, pix_ready}, {31'd0, exp_pr});
        acc = v && exp_pr;
        if (win_valid === 1'b1 && wr) begin
            n_win++;
            if (frame_done === 1'b1) n_fd++;
        end
        @(posedge clk);
        if (!rst) begin
            mrow = 0; mcol = 0; exp_valid = 1'b0; exp_fd = 1'b0;
            for (int k = 0; k < 25; k++) exp_win[k] = 8'd0;
        end else if (acc) begin
            n_acc++;
            if (mrow >= 4 && mcol >= 4) begin
                exp_valid = 1'b1;
                for (int r = 0; r < 5; r++)
                    for (int c = 0; c < 5; c++)
                        exp_win[5*r+c] = img(mrow - 4 + r, mcol - 4 + c);
                exp_fd = (mrow == H - 1) && (mcol == W - 1);
                exp_x  = mcol - 4;
                exp_y  = mrow - 4;
            end else begin
                exp_valid = 1'b0;
                exp_fd    = 1'b0;
            end
            if (mcol == W - 1) begin
                mcol = 0;
                mrow = (mrow == H - 1) ? 0 : mrow + 1;
            end else begin
                mcol++;
            end
        end else if (wr) begin
            exp_valid = 1'b0;
            exp_fd    = 1'b0;
        end
        #1;
        chk("win_valid", {31'd0, win_valid}, {31'd0, exp_valid});
        chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
        if (exp_valid) begin
            chk_win("window");
`ifdef GABOR_WIN_COORD_EN
            chk("win_x", {23'd0, win_x}, exp_x);
            chk("win_y", {23'd0, win_y}, exp_y);
`endif
        end
    endtask

    task automatic chk_zero(input string name);
        for (int k = 0; k < 25; k++) exp_win[k] = 8'd0;
        chk_win(name);
        chk({name, "_valid"}, {31'd0, win_valid}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(1'b1, 1'b1);
        chk_zero("reset_state");
        rst = 1'b1;
    endtask

    initial begin
        logic [9:0] snap [25];
        int cnt;
        bit found, same;

        tbl[0]  = '{76,  1'b0, 8'd0,   8'd0,   8'd0,   1'b0};
        tbl[1]  = '{77,  1'b1, 8'd0,   8'd38,  8'd76,  1'b0};
        tbl[2]  = '{78,  1'b1, 8'd1,   8'd39,  8'd77,  1'b0};
        tbl[3]  = '{90,  1'b1, 8'd13,  8'd51,  8'd89,  1'b0};
        tbl[4]  = '{91,  1'b0, 8'd0,   8'd0,   8'd0,   1'b0};
        tbl[5]  = '{95,  1'b1, 8'd18,  8'd56,  8'd94,  1'b0};
        tbl[6]  = '{257, 1'b1, 8'd180, 8'd218, 8'd0,   1'b0};
        tbl[7]  = '{277, 1'b1, 8'd200, 8'd238, 8'd20,  1'b0};
        tbl[8]  = '{359, 1'b1, 8'd26,  8'd64,  8'd102, 1'b0};
        tbl[9]  = '{360, 1'b1, 8'd27,  8'd65,  8'd103, 1'b1};
        tbl[10] = '{361, 1'b0, 8'd0,   8'd0,   8'd0,   1'b0};
        tbl[11] = '{437, 1'b1, 8'd0,   8'd38,  8'd76,  1'b0};

        mrow = 0; mcol = 0; exp_valid = 1'b0; exp_fd = 1'b0; exp_x = 0; exp_y = 0;
        n_win = 0; n_fd = 0; n_acc = 0;
        pix_valid = 1'b0; win_ready = 1'b0; pix_in = 8'd0;

        // Reset state, then a continuous ramp stream checked against the hand-computed table.
        rst = 1'b0;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        chk_zero("reset_state");
        chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b1;
        n_win = 0; n_fd = 0;
        for (int i = 1; i <= 437; i++) begin
            cyc(1'b1, 1'b1);
            for (int t = 0; t < 12; t++) begin
                if (tbl[t].idx == i) begin
                    if (tbl[t].vld)
                        chk($sformatf("vec%0d", i),
                            {win_valid, pix_o[0], pix_o[12], pix_o[24], frame_done},
                            {1'b1, 2'b00, tbl[t].p1, 2'b00, tbl[t].p13, 2'b00, tbl[t].p25, tbl[t].fd});
                    else
                        chk($sformatf("vec%0d", i), {30'd0, win_valid, frame_done}, 32'd0);
                end
            end
`ifdef GABOR_WIN_COORD_EN
            if (i == 77) begin
                chk("coord_first", {14'd0, win_x, win_y}, 32'd0);
            end
            if (i == 360) begin
                chk("coord_last", {14'd0, win_x, win_y}, {14'd0, 9'(W - 5), 9'(H - 5)});
            end
`endif
            if (i == 361) begin
                chk("frame_windows", n_win, NWIN);
                chk("frame_done_count", n_fd, 1);
            end
        end

        // Consumer stall for 10 cycles while a window is pending.
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            cyc(1'b1, 1'b1);
            if (win_valid === 1'b1) found = 1'b1;
        end
        chk("stall_reach", {31'd0, found}, 32'd1);
        for (int k = 0; k < 25; k++) snap[k] = pix_o[k];
        for (int s = 0; s < 10; s++) begin
            cyc(1'b1, 1'b0);
            same = 1'b1;
            for (int k = 0; k < 25; k++) if (pix_o[k] !== snap[k]) same = 1'b0;
            chk("stall_hold", {31'd0, same}, 32'd1);
        end
        for (int k = 0; k < 300; k++) cyc(1'b1, 1'b1);

        // Random valid gaps and consumer back-pressure over one full frame.
        do_reset();
        n_win = 0; n_fd = 0; n_acc = 0;
        for (int k = 0; k < 5000 && n_acc < W * H; k++)
            cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        chk("gap_accepts", n_acc, W * H);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1);
        chk("gap_windows", n_win, NWIN);
        chk("gap_frame_done", n_fd, 1);

        // Reset mid-frame at row 10, then restart latency.
        do_reset();
        for (int k = 0; k < 400 && mrow < 10; k++) cyc(1'b1, 1'b1);
        chk("mid_row", mrow, 10);
        rst = 1'b0;
        cyc(1'b1, 1'b1);
        chk_zero("mid_reset");
        rst = 1'b1;
        cnt = 0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            cyc(1'b1, 1'b1);
            cnt++;
            if (win_valid === 1'b1) found = 1'b1;
        end
        chk("restart_latency", cnt, 4 * W + 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
